// File: rtl/switch_pkg.sv
// Shared definitions for the switch output-port logic: port count and arbiter FSM states.
package switch_pkg;

    localparam int N_PORTS = 4;
    localparam int IDX_W   = $clog2(N_PORTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/port_arbiter_if.sv
// Handshake bundle between the input ports, the output arbiter and the downstream mux.
interface port_arbiter_if;
    import switch_pkg::*;

    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] in_valid;
    logic [N_PORTS-1:0] in_last;
    logic               out_ready;
    logic [N_PORTS-1:0] sel;
    logic [N_PORTS-1:0] in_ready;
    logic               busy;
    logic               timeout;

    // master: input ports / downstream side driving the arbiter
    modport master (
        output req, in_valid, in_last, out_ready,
        input  sel, in_ready, busy, timeout
    );

    // slave: the arbiter itself
    modport slave (
        input  req, in_valid, in_last, out_ready,
        output sel, in_ready, busy, timeout
    );

endinterface

// File: rtl/port_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts one past last_grant and ascends with wrap.
module rr_pick
    import switch_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [N_PORTS-1:0] rot_req;
    logic [IDX_W-1:0]   rot_idx [N_PORTS];

    // rot_req[0] is the highest-priority candidate this cycle
    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_rot
            assign rot_idx[gi] = last_grant + IDX_W'(gi + 1);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                grant_idx = rot_idx[i];
            end
        end
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Output-port frame arbiter: holds a round-robin grant for a whole frame, then enforces an idle gap.
module port_arbiter
    import switch_pkg::*;
#(
    parameter int MAX_BEATS  = 1518,
    parameter int IFG_CYCLES = 12
)(
    input  logic          clk,
    input  logic          rst_n,
    port_arbiter_if.slave bus
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int GAP_W  = 8;

    arb_state_t         state_q, state_d;
    logic [N_PORTS-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [N_PORTS-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_PORTS-1:0] in_ready_c;
    logic               beat_acc;
    logic               beat_last;

    rr_pick u_rr_pick (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .grant_idx  (pick_idx)
    );

    // sel_q is one-hot while granted, so masking in_valid with in_ready isolates port g
    always_comb begin
        in_ready_c = '0;
        if (state_q == GRANT) begin
            in_ready_c = sel_q & {N_PORTS{bus.out_ready}};
        end
    end

    assign beat_acc  = |(bus.in_valid & in_ready_c);
    assign beat_last = |(bus.in_valid & in_ready_c & bus.in_last);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = GRANT;
                    sel_d       = pick_grant;
                    grant_idx_d = pick_idx;
                    beat_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    // a last beat landing exactly on the limit is a normal end of frame
                    if (beat_last || (beat_cnt_q == BEAT_W'(MAX_BEATS - 1))) begin
                        state_d      = GAP;
                        sel_d        = '0;
                        last_grant_d = grant_idx_q;
                        gap_cnt_d    = '0;
                        timeout_d    = !beat_last;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(IFG_CYCLES - 1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(N_PORTS - 1);
            beat_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.in_ready = in_ready_c;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;

    a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel_q));

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter with MAX_BEATS=4, IFG_CYCLES=12.
module tb_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    port_arbiter_if bus_if ();

    port_arbiter #(
        .MAX_BEATS  (4),
        .IFG_CYCLES (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus_if.req       = 4'b0000;
        bus_if.in_valid  = 4'b0000;
        bus_if.in_last   = 4'b0000;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // steps until sel is non-zero; cyc = steps taken, or -1 if the bound expired
    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (bus_if.sel == 4'b0000 && cyc < 50) begin
            step();
            cyc++;
        end
        if (bus_if.sel == 4'b0000) cyc = -1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        bus_if.req = 4'b1111; bus_if.in_valid = 4'b1111; bus_if.out_ready = 1'b1;
        step();
        step();
        tests++; if (bus_if.sel !== 4'b0000) begin fails++; $display("FAIL reset_sel: got %b expected 0000", bus_if.sel); end
        tests++; if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        tests++; if (bus_if.timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", bus_if.timeout); end
        tests++; if (bus_if.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b expected 0000", bus_if.in_ready); end
        clear_inputs();
        rst_n = 1'b1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic;
        int cyc;
        apply_reset();
        bus_if.req = 4'b0101; bus_if.out_ready = 1'b1;
        wait_grant(cyc);
        tests++; if (cyc !== 1) begin fails++; $display("FAIL basic_grant_latency: got %0d expected 1", cyc); end
        tests++; if (bus_if.sel !== 4'b0001) begin fails++; $display("FAIL basic_sel0: got %b expected 0001", bus_if.sel); end
        bus_if.in_valid = 4'b0001; bus_if.in_last = 4'b0000;
        #1;
        tests++; if (bus_if.in_ready !== 4'b0001) begin fails++; $display("FAIL basic_in_ready: got %b expected 0001", bus_if.in_ready); end
        step();
        step();
        bus_if.in_last = 4'b0001;
        step();
        bus_if.in_valid = 4'b0000; bus_if.in_last = 4'b0000;
        tests++; if (bus_if.sel !== 4'b0000) begin fails++; $display("FAIL basic_gap_sel: got %b expected 0000", bus_if.sel); end
        tests++; if (bus_if.busy !== 1'b1) begin fails++; $display("FAIL basic_gap_busy: got %b expected 1", bus_if.busy); end
        tests++; if (bus_if.timeout !== 1'b0) begin fails++; $display("FAIL basic_gap_timeout: got %b expected 0", bus_if.timeout); end
        wait_grant(cyc);
        tests++; if (cyc !== 13) begin fails++; $display("FAIL basic_gap_len: got %0d expected 13", cyc); end
        tests++; if (bus_if.sel !== 4'b0100) begin fails++; $display("FAIL basic_sel2: got %b expected 0100", bus_if.sel); end
        bus_if.in_valid = 4'b0100; bus_if.in_last = 4'b0100;
        step();
        clear_inputs();
        $display("[TB] test_basic done");
    endtask

    task automatic test_round_robin;
        int cyc;
        logic [3:0] expv;
        apply_reset();
        bus_if.req = 4'b1111; bus_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expv = 4'b0001 << (i % 4);
            wait_grant(cyc);
            tests++; if (bus_if.sel !== expv) begin fails++; $display("FAIL rr_sel[%0d]: got %b expected %b", i, bus_if.sel, expv); end
            if (i == 0) begin
                tests++; if (cyc !== 1) begin fails++; $display("FAIL rr_first_latency: got %0d expected 1", cyc); end
            end else begin
                tests++; if (cyc + 1 !== 14) begin fails++; $display("FAIL rr_spacing[%0d]: got %0d expected 14", i, cyc + 1); end
            end
            bus_if.in_valid = bus_if.sel; bus_if.in_last = bus_if.sel;
            step();
            bus_if.in_valid = 4'b0000; bus_if.in_last = 4'b0000;
        end
        clear_inputs();
        $display("[TB] test_round_robin done");
    endtask

    task automatic test_timeout;
        int cyc;
        int acc = 0;
        int pulses = 0;
        int pulse_k = -1;
        apply_reset();
        bus_if.req = 4'b0100; bus_if.out_ready = 1'b1;
        wait_grant(cyc);
        tests++; if (bus_if.sel !== 4'b0100) begin fails++; $display("FAIL to_sel: got %b expected 0100", bus_if.sel); end
        bus_if.in_valid = 4'b0100; bus_if.in_last = 4'b0000;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (bus_if.in_ready[2] && bus_if.in_valid[2]) acc++;
            step();
            if (bus_if.timeout) begin pulses++; pulse_k = k; end
        end
        tests++; if (acc !== 4) begin fails++; $display("FAIL to_beats: got %0d expected 4", acc); end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
        tests++; if (pulse_k !== 3) begin fails++; $display("FAIL to_pulse_cycle: got %0d expected 3", pulse_k); end
        tests++; if (bus_if.sel !== 4'b0000) begin fails++; $display("FAIL to_sel_after: got %b expected 0000", bus_if.sel); end
        tests++; if (bus_if.in_ready[2] !== 1'b0) begin fails++; $display("FAIL to_in_ready2: got %b expected 0", bus_if.in_ready[2]); end
        tests++; if (bus_if.busy !== 1'b1) begin fails++; $display("FAIL to_busy: got %b expected 1", bus_if.busy); end
        clear_inputs();
        $display("[TB] test_timeout done");
    endtask

    task automatic test_max_last;
        int cyc;
        int pulses = 0;
        apply_reset();
        bus_if.req = 4'b0001; bus_if.out_ready = 1'b1;
        wait_grant(cyc);
        bus_if.in_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            bus_if.in_last = (k == 3) ? 4'b0001 : 4'b0000;
            step();
            if (bus_if.timeout) pulses++;
        end
        bus_if.in_valid = 4'b0000; bus_if.in_last = 4'b0000;
        step();
        if (bus_if.timeout) pulses++;
        tests++; if (pulses !== 0) begin fails++; $display("FAIL maxlast_pulses: got %0d expected 0", pulses); end
        tests++; if (bus_if.sel !== 4'b0000) begin fails++; $display("FAIL maxlast_sel: got %b expected 0000", bus_if.sel); end
        clear_inputs();
        $display("[TB] test_max_last done");
    endtask

    task automatic test_stall;
        int cyc;
        int acc = 0;
        int n = 0;
        int pulses = 0;
        logic [3:0] exp_rdy;
        apply_reset();
        bus_if.req = 4'b0010;
        wait_grant(cyc);
        tests++; if (bus_if.sel !== 4'b0010) begin fails++; $display("FAIL stall_sel: got %b expected 0010", bus_if.sel); end
        bus_if.in_valid = 4'b0010;
        while (bus_if.sel != 4'b0000 && n < 20) begin
            bus_if.out_ready = (n % 2) == 1;
            bus_if.in_last = (acc == 2) ? 4'b0010 : 4'b0000;
            exp_rdy = ((n % 2) == 1) ? 4'b0010 : 4'b0000;
            #1;
            tests++; if (bus_if.in_ready !== exp_rdy) begin fails++; $display("FAIL stall_in_ready[%0d]: got %b expected %b", n, bus_if.in_ready, exp_rdy); end
            if (bus_if.in_ready[1]) acc++;
            step();
            n++;
            if (bus_if.timeout) pulses++;
        end
        tests++; if (acc !== 3) begin fails++; $display("FAIL stall_beats: got %0d expected 3", acc); end
        tests++; if (n !== 6) begin fails++; $display("FAIL stall_cycles: got %0d expected 6", n); end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL stall_timeout: got %0d expected 0", pulses); end
        clear_inputs();
        $display("[TB] test_stall done");
    endtask

    task automatic test_reset_midframe;
        int cyc;
        apply_reset();
        bus_if.req = 4'b1000; bus_if.out_ready = 1'b1;
        wait_grant(cyc);
        tests++; if (bus_if.sel !== 4'b1000) begin fails++; $display("FAIL midrst_sel3: got %b expected 1000", bus_if.sel); end
        bus_if.in_valid = 4'b1000; bus_if.in_last = 4'b0000;
        step();
        rst_n = 1'b0;
        step();
        tests++; if (bus_if.sel !== 4'b0000) begin fails++; $display("FAIL midrst_sel: got %b expected 0000", bus_if.sel); end
        tests++; if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", bus_if.busy); end
        tests++; if (bus_if.timeout !== 1'b0) begin fails++; $display("FAIL midrst_timeout: got %b expected 0", bus_if.timeout); end
        tests++; if (bus_if.in_ready !== 4'b0000) begin fails++; $display("FAIL midrst_in_ready: got %b expected 0000", bus_if.in_ready); end
        rst_n = 1'b1;
        wait_grant(cyc);
        tests++; if (cyc !== 1) begin fails++; $display("FAIL midrst_regrant_latency: got %0d expected 1", cyc); end
        tests++; if (bus_if.sel !== 4'b1000) begin fails++; $display("FAIL midrst_regrant: got %b expected 1000", bus_if.sel); end
        bus_if.in_last = 4'b1000;
        step();
        clear_inputs();
        $display("[TB] test_reset_midframe done");
    endtask

    task automatic test_req_drop;
        int cyc;
        apply_reset();
        bus_if.req = 4'b0001; bus_if.out_ready = 1'b1;
        wait_grant(cyc);
        bus_if.req = 4'b0000;
        bus_if.in_valid = 4'b1111; bus_if.in_last = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (bus_if.sel !== 4'b0001) begin fails++; $display("FAIL drop_sel[%0d]: got %b expected 0001", k, bus_if.sel); end
            tests++; if (bus_if.in_ready !== 4'b0001) begin fails++; $display("FAIL drop_in_ready[%0d]: got %b expected 0001", k, bus_if.in_ready); end
            step();
        end
        bus_if.in_last = 4'b1111;
        step();
        tests++; if (bus_if.sel !== 4'b0000) begin fails++; $display("FAIL drop_end_sel: got %b expected 0000", bus_if.sel); end
        tests++; if (bus_if.timeout !== 1'b0) begin fails++; $display("FAIL drop_end_timeout: got %b expected 0", bus_if.timeout); end
        clear_inputs();
        $display("[TB] test_req_drop done");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_max_last();
        test_stall();
        test_reset_midframe();
        test_req_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_BEATS, default 1518, the maximum accepted beats per frame before forced release.
REQ-002 The module SHALL have parameter IFG_CYCLES, default 12, the idle gap cycles between frames; legal range 1..255.
REQ-003 Port: clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-low reset.
REQ-005 Port: req  in  4  per-input-port "frame pending for this output" flags.
REQ-006 Port: in_valid  in  4  per-port data beat valid.
REQ-007 Port: in_last  in  4  per-port last beat of frame; qualified by in_valid.
REQ-008 Port: out_ready  in  1  downstream can accept a beat this cycle.
REQ-009 Port: sel  out  4  one-hot grant, registered; drives the select input of the downstream 4:1 output mux.
REQ-010 Port: in_ready  out  4  per-port beat accept; combinational.
REQ-011 Port: busy  out  1  high in the GRANT and GAP states.
REQ-012 Port: timeout  out  1  one-cycle pulse on forced frame release.

Function
REQ-013 FSM states SHALL be IDLE, GRANT and GAP.
REQ-014 IDLE with req != 0: the next cycle SHALL have state GRANT and sel equal to the one-hot round-robin winner.
REQ-015 IDLE with req == 0: state and sel SHALL remain unchanged (sel = 0).
REQ-016 Round-robin search SHALL start at (last_grant+1) mod 4 and ascend with wrap; last_grant is the port index of the last completed grant.
REQ-017 In GRANT, in_ready SHALL equal sel AND out_ready (replicated to 4 bits); in all other states in_ready SHALL be 0.
REQ-018 A beat SHALL be accepted when in_valid[g] && in_ready[g], where g is the granted port; in_valid on non-granted ports SHALL be ignored.
REQ-019 Beat counter: cleared on entering GRANT; incremented by 1 per accepted beat; width $clog2(MAX_BEATS+1); SHALL never wrap.
REQ-020 An accepted beat with in_last[g]=1 SHALL cause the next cycle to have state GAP, sel=0, and last_grant=g.
REQ-021 The MAX_BEATS-th accepted beat with in_last[g]=0 SHALL cause the next cycle to have state GAP, sel=0, last_grant=g, and timeout=1 for exactly one cycle.
REQ-022 If in_last[g] is high on the MAX_BEATS-th beat, this SHALL be a normal end of frame with no timeout pulse.
REQ-023 Deassertion of req[g] during GRANT SHALL be ignored; the grant SHALL be held until last or timeout.
REQ-024 GAP SHALL last exactly IFG_CYCLES cycles, then the FSM SHALL go to IDLE; req SHALL be ignored during GAP.
REQ-025 Minimum latency from the last beat to the next sel assertion SHALL be IFG_CYCLES+2 cycles; the gap covers the one-cycle select register in the downstream mux.
REQ-026 sel SHALL always be 0 or one-hot; multiple bits set is illegal and SHALL be covered by an assertion.
REQ-027 out_ready low SHALL stall beats without affecting the grant, the counters or the FSM state.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state=IDLE, sel=0, busy=0, timeout=0, beat and gap counters=0, and last_grant=3 (port 0 wins first).
REQ-029 Reset asserted mid-frame SHALL abort the frame with no timeout pulse; in_ready SHALL be 0 in the following cycle.

Structure
REQ-030 The shared switch_pkg package SHALL hold: N_PORTS=4 and the arb_state_t enum (IDLE, GRANT, GAP).
REQ-031 Sub-module rr_pick SHALL be purely combinational: inputs req[3:0] and last_grant[1:0]; outputs a one-hot grant and its index.
REQ-032 sel, state, counters and last_grant SHALL be registers; in_ready SHALL be the only combinational output.

Verification
REQ-033 Reset, then req=4'b0101 -> sel=4'b0001 one cycle later; 3 beats, last on beat 3 -> 12 GAP cycles, then sel=4'b0100.
REQ-034 req=4'b1111 held, 1-beat frames -> grant order 0,1,2,3,0; sel assertions spaced 14 cycles apart.
REQ-035 MAX_BEATS=4, port 2 sends 6 beats with no last -> 4 beats accepted, timeout pulse for 1 cycle, sel=0, in_ready[2]=0.
REQ-036 Granted port 1 with out_ready toggled every cycle -> beats accepted only when out_ready=1; frame completes with the correct beat count.
REQ-037 rst_n low for 1 cycle mid-frame on port 3 -> all outputs 0 next cycle; with req=4'b1000, the next grant goes to port 3 (search starts at port 0).
REQ-038 req[0] dropped mid-frame -> sel=4'b0001 held until in_last accepted; valid on non-granted ports -> never accepted.
